multiword_add_controller: RTL and testbench



---
 rtl/multiword_add_controller.sv | 133 +++++++++++++
 tb/tb_multiword_add_controller.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/multiword_add_controller.sv
// Wide add/subtract sequencer: one shared 16-bit carry-select adder is reused
// for every 16-bit slice, least-significant slice first, with the carry held between slices.
module multiword_add_controller #(
  parameter int WORDS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                op,
  input  logic [16*WORDS-1:0] a,
  input  logic [16*WORDS-1:0] b,
  input  logic                cin,
  output logic                busy,
  output logic                done,
  output logic [16*WORDS-1:0] sum,
  output logic                cout,
  output logic                ovf
);
  localparam int W     = 16 * WORDS;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             r_state;
  logic [W-1:0]       r_opa;
  logic [W-1:0]       r_opb;
  logic               r_carry;
  logic [IDX_W-1:0]   r_idx;

  logic [15:0] w_slice_a;
  logic [15:0] w_slice_b;
  logic [15:0] w_slice_sum;
  logic        w_slice_cout;
  logic        w_last;

  assign w_slice_a = r_opa[r_idx*16 +: 16];
  assign w_slice_b = r_opb[r_idx*16 +: 16];
  assign w_last    = (r_idx == IDX_W'(WORDS - 1));

  carry_select_adder u_adder (
    .i_a    (w_slice_a),
    .i_b    (w_slice_b),
    .i_cin  (r_carry),
    .o_sum  (w_slice_sum),
    .o_cout (w_slice_cout)
  );

  // Operand registers are pure data and are only loaded on acceptance.
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && start && !rst) begin
      r_opa <= a;
      r_opb <= op ? ~b : b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_carry <= 1'b0;
      r_idx   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_carry <= op | cin;
            r_idx   <= '0;
            sum     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
            busy    <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          sum[r_idx*16 +: 16] <= w_slice_sum;
          r_carry             <= w_slice_cout;
          if (w_last) begin
            // Overflow = carry into MSB xor carry out of MSB; carry-in recovered from the sum bit.
            cout    <= w_slice_cout;
            ovf     <= r_opa[W-1] ^ r_opb[W-1] ^ w_slice_sum[15] ^ w_slice_cout;
            done    <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        S_DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// 16-bit carry-select adder: four 4-bit blocks, each precomputed for carry-in 0 and 1
// and selected by the incoming block carry.
module carry_select_adder (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  input  logic        i_cin,
  output logic [15:0] o_sum,
  output logic        o_cout
);
  logic [4:0] w_lo;
  logic [4:0] w_hi;
  logic       w_c;

  always_comb begin
    w_c   = i_cin;
    w_lo  = '0;
    w_hi  = '0;
    o_sum = '0;
    for (int k = 0; k < 4; k++) begin
      w_lo = {1'b0, i_a[k*4 +: 4]} + {1'b0, i_b[k*4 +: 4]};
      w_hi = w_lo + 5'd1;
      o_sum[k*4 +: 4] = w_c ? w_hi[3:0] : w_lo[3:0];
      w_c = w_c ? w_hi[4] : w_lo[4];
    end
    o_cout = w_c;
  end
endmodule

// File: tb/tb_multiword_add_controller.sv
// Directed and random jobs for the 4-slice controller, checked against an arithmetic reference model.
module tb_multiword_add_controller;
  localparam int WORDS = 4;
  localparam int W     = 16 * WORDS;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int errors = 0;
  int checks = 0;

  multiword_add_controller #(.WORDS(WORDS)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: plain full-width arithmetic, unsigned compare for borrow, sign rules for overflow.
  function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                input logic mop, input logic mcin,
                                output logic [W-1:0] s, output logic c, output logic v);
    logic [W:0] full;
    if (!mop) begin
      full = {1'b0, ma} + {1'b0, mb} + (W+1)'(mcin);
      s = full[W-1:0];
      c = full[W];
      v = (ma[W-1] == mb[W-1]) && (s[W-1] != ma[W-1]);
    end else begin
      s = ma - mb;
      c = (ma >= mb);
      v = (ma[W-1] != mb[W-1]) && (s[W-1] != ma[W-1]);
    end
  endfunction

  // Issue one job, optionally poke start with other operands while busy, then check the result.
  task automatic do_job(input logic [W-1:0] ja, input logic [W-1:0] jb, input logic jop,
                        input logic jcin, input logic poke, input string tag);
    logic [W-1:0] es;
    logic         ec;
    logic         ev;
    int           lat;
    model(ja, jb, jop, jcin, es, ec, ev);
    @(negedge clk);
    a = ja; b = jb; op = jop; cin = jcin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = {$urandom(), $urandom()}; b = {$urandom(), $urandom()}; op = ~jop; cin = ~jcin;
    check({tag, "_busy_accept"}, W'(busy), W'(1));
    lat = 0;
    while (!done && lat < 20) begin
      if (poke && lat == 0) begin
        start = 1'b1; a = {4{16'hAAAA}}; b = {4{16'h5555}}; op = 1'b0;
      end
      @(posedge clk); #1;
      start = 1'b0;
      lat++;
    end
    check({tag, "_done_edge"}, W'(lat), W'(WORDS));
    check({tag, "_sum"}, sum, es);
    check({tag, "_cout"}, W'(cout), W'(ec));
    check({tag, "_ovf"}, W'(ovf), W'(ev));
    @(posedge clk); #1;
    check({tag, "_done_pulse_width"}, W'({done, busy}), W'(0));
  endtask

  initial begin
    logic         seen;
    int           ndone, nlow, last_done;
    logic [W-1:0] held;

    rst = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {busy, done, cout, ovf, sum[59:0]}, '0);
    check("reset_sum", sum, '0);
    @(negedge clk); rst = 1'b0;

    do_job(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, 1'b0, "add_ffff");
    do_job(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b0, 1'b1, 1'b0, "add_ripple");
    do_job(64'd5, 64'd7, 1'b1, 1'b0, 1'b0, "sub_5_7");
    do_job(64'd7, 64'd5, 1'b1, 1'b1, 1'b0, "sub_7_5");
    do_job(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 1'b0, "add_posovf");
    do_job(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b0, "add_negovf");
    do_job(64'd1, 64'd1, 1'b0, 1'b0, 1'b1, "busy_ignore");

    held = sum;
    repeat (3) @(posedge clk);
    #1;
    check("sum_held", sum, held);

    // Reset one edge after acceptance aborts the job.
    @(negedge clk);
    a = 64'h1234; b = 64'h1111; op = 1'b0; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_outputs", {busy, done, cout, ovf}, '0);
    check("abort_sum", sum, '0);
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    check("abort_no_done", W'(seen), W'(0));

    for (int i = 0; i < 8; i++) begin
      do_job({$urandom(), $urandom()}, {$urandom(), $urandom()}, 1'($urandom()),
             1'($urandom()), 1'b0, "random");
    end

    // Back-to-back jobs with start held high.
    @(negedge clk);
    a = 64'd3; b = 64'd4; op = 1'b0; cin = 1'b0; start = 1'b1;
    ndone = 0; nlow = 0; last_done = -1;
    for (int e = 0; e < 20; e++) begin
      @(posedge clk); #1;
      if (!busy) nlow++;
      if (done) begin
        check("stream_sum", sum, 64'd7);
        if (last_done >= 0) check("stream_period", W'(e - last_done), W'(WORDS + 2));
        last_done = e;
        ndone++;
      end
    end
    start = 1'b0;
    check("stream_done_count", W'(ndone), W'(3));
    check("stream_busy_low", W'(nlow), W'(3));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
